// File: rtl/nes_pad_reader.sv
// NES/SNES-style controller reader: latches the pad, shifts eight bits in over
// the serial line and presents them as active-high button state.
module nes_pad_reader #(
   parameter int TICK_DIV = 150
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       poll,
   input  logic       nes_data,
   output logic       nes_latch,
   output logic       nes_clk,
   output logic [7:0] buttons,
   output logic       valid,
   output logic       pad_absent,
   output logic       busy,
   output logic [2:0] dbg_state
);

   localparam int CW = $clog2(TICK_DIV);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LATCH = 3'd1,
      S_LOW   = 3'd2,
      S_HIGH  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state;
   logic [CW-1:0]   tick_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      raw;
   logic [7:0]      raw_next;
   logic [1:0]      sync_q;
   logic            tick;

   assign tick      = (tick_cnt == CW'(TICK_DIV - 1));
   assign dbg_state = state;

   // Raw image including the bit being captured this cycle, so the final
   // LOW tick can publish all eight bits in the same edge that raises valid.
   always_comb begin
      raw_next          = raw;
      raw_next[bit_idx] = sync_q[1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], nes_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         tick_cnt   <= '0;
         bit_idx    <= 3'd0;
         raw        <= 8'h00;
         nes_latch  <= 1'b0;
         nes_clk    <= 1'b1;
         buttons    <= 8'h00;
         valid      <= 1'b0;
         pad_absent <= 1'b0;
         busy       <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (state == S_LATCH || state == S_LOW || state == S_HIGH) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (poll) begin
                  state     <= S_LATCH;
                  nes_latch <= 1'b1;
                  busy      <= 1'b1;
                  tick_cnt  <= '0;
                  bit_idx   <= 3'd0;
               end
            end
            // bit_idx doubles as the latch tick count before the shift starts
            S_LATCH: begin
               if (tick) begin
                  if (bit_idx == 3'd1) begin
                     state     <= S_LOW;
                     nes_latch <= 1'b0;
                     nes_clk   <= 1'b0;
                     bit_idx   <= 3'd0;
                  end else begin
                     bit_idx <= 3'd1;
                  end
               end
            end
            S_LOW: begin
               if (tick) begin
                  raw[bit_idx] <= sync_q[1];
                  nes_clk      <= 1'b1;
                  if (bit_idx == 3'd7) begin
                     state      <= S_DONE;
                     valid      <= 1'b1;
                     buttons    <= ~raw_next;
                     pad_absent <= (raw_next == 8'h00);
                  end else begin
                     state <= S_HIGH;
                  end
               end
            end
            S_HIGH: begin
               if (tick) begin
                  state   <= S_LOW;
                  nes_clk <= 1'b0;
                  bit_idx <= bit_idx + 3'd1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: a shift-register pad model, a driver that predicts
// each accepted read, and a negedge monitor that scores every valid pulse.
module tb_nes_pad_reader;

   localparam int T    = 4;
   localparam int READ = 17 * T;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       poll = 1'b0;
   logic       nes_data = 1'b1;
   logic       nes_latch;
   logic       nes_clk;
   logic [7:0] buttons;
   logic       valid;
   logic       pad_absent;
   logic       busy;
   logic [2:0] dbg_state;

   nes_pad_reader #(.TICK_DIV(T)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .poll       (poll),
      .nes_data   (nes_data),
      .nes_latch  (nes_latch),
      .nes_clk    (nes_clk),
      .buttons    (buttons),
      .valid      (valid),
      .pad_absent (pad_absent),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: a read accepted in cycle c is busy over c+1 .. c+1+17T,
   // holds the latch for the first 2T of those cycles and reports in the last.
   int         start_cyc = 1;
   int         end_cyc   = 0;
   int         last_rst  = -10;
   logic [8:0] exp_q[$];
   int         exp_cyc_q[$];
   logic       checking   = 1'b0;
   logic       finish_req = 1'b0;

   // pad_mode: 0 = shift register, 1 = line stuck low, 2 = line stuck high,
   // 3 = shift register with a one-cycle wrong level after each nes_clk rise
   logic [1:0] pad_mode = 2'd0;
   logic [7:0] pad_raw  = 8'hFF;

   function automatic logic [8:0] expected_of(input logic [1:0] m, input logic [7:0] r);
      logic [7:0] line;
      line = (m == 2'd1) ? 8'h00 : (m == 2'd2) ? 8'hFF : r;
      return {line == 8'h00, ~line};
   endfunction

   // ---------------- pad model ----------------
   initial begin : pad_model
      logic [7:0] sh;
      logic       prev_clk;
      logic       glitch;
      sh       = 8'hFF;
      prev_clk = 1'b1;
      forever begin
         @(negedge clk);
         glitch = 1'b0;
         if (nes_latch) begin
            sh = pad_raw;
         end else if (nes_clk && !prev_clk) begin
            sh     = {1'b1, sh[7:1]};
            glitch = (pad_mode == 2'd3);
         end
         prev_clk = nes_clk;
         case (pad_mode)
            2'd1:    nes_data = 1'b0;
            2'd2:    nes_data = 1'b1;
            default: nes_data = sh[0] ^ glitch;
         endcase
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic p, input logic rn);
      @(posedge clk);
      #1;
      poll  = p;
      rst_n = rn;
      if (!rn) begin
         if (end_cyc > cyc) end_cyc = cyc;
         while (exp_cyc_q.size() > 0 && exp_cyc_q[$] > cyc) begin
            void'(exp_q.pop_back());
            void'(exp_cyc_q.pop_back());
         end
         last_rst = cyc;
      end else if (p && cyc > end_cyc) begin
         start_cyc = cyc + 1;
         end_cyc   = cyc + 1 + READ;
         exp_q.push_back(expected_of(pad_mode, pad_raw));
         exp_cyc_q.push_back(end_cyc);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b1);
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while (cyc < end_cyc && guard < 500) begin
         drive(1'b0, 1'b1);
         guard++;
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   initial begin : monitor
      logic       prev_clk;
      logic       busy_e;
      logic       latch_e;
      logic [7:0] hold_btn;
      logic       hold_abs;
      logic [8:0] e;
      int         e_cyc;
      int         latch_n;
      int         low_n;
      int         rise_n;
      prev_clk = 1'b1;
      hold_btn = 8'h00;
      hold_abs = 1'b0;
      latch_n  = 0;
      low_n    = 0;
      rise_n   = 0;
      forever begin
         @(negedge clk);
         busy_e  = (cyc >= start_cyc) && (cyc <= end_cyc);
         latch_e = busy_e && (cyc <= start_cyc + 2 * T - 1);
         if (checking) begin
            if (cyc == last_rst + 1) begin
               hold_btn = 8'h00;
               hold_abs = 1'b0;
               check("reset_nes_latch", int'(nes_latch), 0);
               check("reset_nes_clk", int'(nes_clk), 1);
               check("reset_valid", int'(valid), 0);
               check("reset_busy", int'(busy), 0);
            end
            check("busy", int'(busy), int'(busy_e));
            check("nes_latch", int'(nes_latch), int'(latch_e));
            if (busy_e) begin
               if (nes_latch) latch_n++;
               if (!nes_clk) low_n++;
               if (nes_clk && !prev_clk) rise_n++;
            end
            if (valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_valid", 1, 0);
               end else begin
                  e     = exp_q.pop_front();
                  e_cyc = exp_cyc_q.pop_front();
                  check("valid_cycle", cyc, e_cyc);
                  check("read_result", int'({pad_absent, buttons}), int'(e));
                  check("latch_cycles", latch_n, 2 * T);
                  check("clk_low_cycles", low_n, 8 * T);
                  check("clk_rise_count", rise_n, 8);
                  hold_abs = e[8];
                  hold_btn = e[7:0];
               end
            end else if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0]) begin
               check("valid_missing", 0, 1);
               void'(exp_q.pop_front());
               void'(exp_cyc_q.pop_front());
            end
            check("buttons_hold", int'(buttons), int'(hold_btn));
            check("pad_absent_hold", int'(pad_absent), int'(hold_abs));
            if (!busy_e) begin
               latch_n = 0;
               low_n   = 0;
               rise_n  = 0;
            end
            if (finish_req) begin
               check("queue_drained", exp_q.size(), 0);
               $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
               $finish;
            end
         end
         prev_clk = nes_clk;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin : stimulus
      int len;
      int r;
      repeat (3) drive(1'b0, 1'b0);
      drive(1'b0, 1'b1);
      checking = 1'b1;
      idle(3);

      // A pressed
      pad_mode = 2'd0;
      pad_raw  = 8'b1111_1110;
      drive(1'b1, 1'b1);
      idle(READ + 10);

      // line stuck low, then stuck high
      pad_mode = 2'd1;
      drive(1'b1, 1'b1);
      idle(READ + 10);
      pad_mode = 2'd2;
      drive(1'b1, 1'b1);
      idle(READ + 10);

      // polls while busy and in the DONE cycle are dropped; the next one lands
      pad_mode = 2'd0;
      pad_raw  = 8'b1011_0101;
      drive(1'b1, 1'b1);
      for (int k = 1; k <= 70; k++) begin
         drive((k == 5) || (k == 40) || (k == 69) || (k == 70), 1'b1);
      end
      idle(READ + 10);

      // reset mid-read
      pad_raw = 8'b0000_1111;
      drive(1'b1, 1'b1);
      idle(29);
      drive(1'b0, 1'b0);
      idle(READ + 30);

      // Up+Right with glitching data on every nes_clk rise
      pad_mode = 2'd3;
      pad_raw  = 8'b0110_1111;
      drive(1'b1, 1'b1);
      idle(READ + 10);

      // randomized reads, stray polls and occasional resets
      for (int it = 0; it < 30; it++) begin
         wait_idle();
         pad_mode = 2'($urandom_range(0, 3));
         pad_raw  = 8'($urandom_range(0, 255));
         drive(1'b1, 1'b1);
         len = $urandom_range(20, 100);
         for (int k = 0; k < len; k++) begin
            r = $urandom_range(0, 199);
            drive(r < 12, r != 199);
         end
      end

      wait_idle();
      idle(5);
      finish_req = 1'b1;
   end

endmodule

// File: doc/nes_pad_reader.md
NES_PAD_READER -- requirements
Module: nes_pad_reader

Interface
REQ-001 SHALL have parameter TICK_DIV, default 150, meaning clk cycles per protocol phase (legal range 4..1023).
REQ-002 SHALL have port clk  input  1  system clock (25.175 MHz pixel clock).
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port poll  input  1  single-cycle read request (driven by the sync generator's frame_end).
REQ-005 SHALL have port nes_data  input  1  serial data from the controller, active-low, asynchronous.
REQ-006 SHALL have port nes_latch  output  1  controller latch strobe, registered.
REQ-007 SHALL have port nes_clk  output  1  controller shift clock, registered, idles high.
REQ-008 SHALL have port buttons  output  8  active-high button state {Right,Left,Down,Up,Start,Select,B,A}, bit0 = A.
REQ-009 SHALL have port valid  output  1  one-cycle pulse when buttons updates.
REQ-010 SHALL have port pad_absent  output  1  last read returned all-zero raw data (line stuck low).
REQ-011 SHALL have port busy  output  1  high while a read is in progress.

Function
REQ-012 SHALL pass nes_data through a 2-flop synchroniser before any use.
REQ-013 SHALL implement FSM states IDLE, LATCH, LOW, HIGH, DONE.
REQ-014 SHALL keep a tick counter 0..TICK_DIV-1 that is cleared on leaving IDLE; a tick is the cycle the counter equals TICK_DIV-1.
REQ-015 IDLE: nes_latch=0, nes_clk=1, busy=0; poll=1 moves to LATCH on the next edge.
REQ-016 LATCH: nes_latch=1 for exactly 2 ticks (2*TICK_DIV cycles), then LOW with bit index 0.
REQ-017 LOW: nes_latch=0, nes_clk=0 for 1 tick; on the tick cycle the synchronised data is stored at raw[index].
REQ-018 After LOW with index 0..6: HIGH for 1 tick (nes_clk=1), then LOW with index+1.
REQ-019 After LOW with index 7: DONE; nes_clk returns high (8th rising edge, harmless).
REQ-020 DONE, single cycle: buttons <= ~raw; valid=1; pad_absent <= (raw == 8'h00); then IDLE.
REQ-021 Latency: poll at cycle N gives nes_latch high from N+1, and valid at N+1+17*TICK_DIV (2 latch ticks + 8 low + 7 high).
REQ-022 busy SHALL be 1 in LATCH, LOW, HIGH and DONE.
REQ-023 poll while busy SHALL be ignored with no queuing; a poll in the DONE cycle is also ignored.
REQ-024 buttons and pad_absent SHALL hold between reads; partial reads never alter buttons.
REQ-025 Bit index SHALL be 3 bits; the tick counter SHALL be wide enough for TICK_DIV-1 and never wrap mid-phase.

Reset
REQ-026 rst_n=0 at any clock edge, including mid-read, SHALL force next cycle: IDLE, nes_latch=0, nes_clk=1, buttons=0, valid=0, pad_absent=0, busy=0, counters and raw=0.
REQ-027 A poll in a cycle with rst_n=0 SHALL be ignored.

Verification (TICK_DIV=4, poll at cycle 0)
REQ-028 Pad model drives raw 8'b1111_1110 (A pressed) -> nes_latch high cycles 1..8, 8 nes_clk low pulses of 4 cycles, valid at cycle 69, buttons=8'h01, pad_absent=0.
REQ-029 nes_data tied 0 -> buttons=8'hFF, pad_absent=1; then nes_data tied 1 and poll -> buttons=8'h00, pad_absent=0.
REQ-030 Extra poll pulses at cycles 5, 40 and 69 -> exactly one valid, at cycle 69; next poll accepted from cycle 70.
REQ-031 rst_n low at cycle 30 mid-read -> cycle 31 nes_latch=0, nes_clk=1, busy=0, buttons=0; no valid until a new poll.
REQ-032 Pad model presents Up+Right (raw 8'b0110_1111) with a 1-cycle data change coinciding with each nes_clk rising edge -> buttons=8'h90; nes_clk edge count per read = 8.
